seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle add/subtract unit, successor to the fixed 16-bit ripple-carry adder.
- Splits WIDTH-bit operands into CHUNK-bit slices and ripples one slice per clock through a registered carry. Large widths are handled without a long combinational carry chain.
- Valid/ready handshake on both sides; reports sum, carry-out and signed overflow.
- Sits in the datapath library as the area-lean alternative to the flat combinational RCA.

---
 rtl/seq_chunk_adder_pkg.sv | 11 +
 rtl/seq_chunk_adder_if.sv | 28 ++
 rtl/seq_chunk_adder_rca_chunk.sv | 23 ++
 rtl/seq_chunk_adder.sv | 134 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared constants for the sequential chunked adder: FSM encoding and operation modes.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder; master drives operands, slave is the unit.
interface seq_chunk_adder_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/seq_chunk_adder_rca_chunk.sv
// Combinational N-bit carry-propagate slice; c_msb is the carry into bit N-1 for overflow detection.
module rca_chunk #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb
);

    localparam int unsigned NW = N + 1;

    logic [N:0] total;

    assign total = {1'b0, x} + {1'b0, y} + NW'(ci);
    assign s     = total[N-1:0];
    assign co    = total[N];
    // Sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out of the MSB sum bit.
    assign c_msb = s[N-1] ^ x[N-1] ^ y[N-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: ripples one CHUNK-bit slice per clock through a registered carry.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic              clk,
    input logic              rst_n,
    seq_chunk_adder_if.slave bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0]      off;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_msb;

    assign off = 32'(idx_q) * CHUNK;

    rca_chunk #(.N(CHUNK)) u_rca (
        .x     (a_q[off +: CHUNK]),
        .y     (b_q[off +: CHUNK]),
        .ci    (carry_q),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    // Subtraction is a + ~b + 1, so cin is ignored in that mode.
                    a_d        = bus.a;
                    b_d        = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
                    carry_d    = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                sum_d[off +: CHUNK] = slice_s;
                carry_d             = slice_co;
                if (idx_q == IDX_LAST) begin
                    cout_d      = slice_co;
                    ovf_d       = slice_c_msb ^ slice_co;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder across four parameter sets sharing one clock and reset.
module tb_seq_chunk_adder;
    import adder_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_chunk_adder_if #(.WIDTH(16)) if_m ();
    seq_chunk_adder_if #(.WIDTH(16)) if_1 ();
    seq_chunk_adder_if #(.WIDTH(16)) if_16 ();
    seq_chunk_adder_if #(.WIDTH(32)) if_32 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_m  (.clk(clk), .rst_n(rst_n), .bus(if_m));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_1  (.clk(clk), .rst_n(rst_n), .bus(if_1));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_16 (.clk(clk), .rst_n(rst_n), .bus(if_16));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  u_32 (.clk(clk), .rst_n(rst_n), .bus(if_32));

    // Instance selector: 0 = 16/4, 1 = 16/1, 2 = 16/16, 3 = 32/8.
    function automatic int w_of(input int sel);
        return (sel == 3) ? 32 : 16;
    endfunction

    function automatic int nchunk_of(input int sel);
        case (sel)
            0:       return 4;
            1:       return 16;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [31:0] mask;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [32:0] full;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa     = a & mask;
        bb     = sub ? (~b & mask) : (b & mask);
        full   = {1'b0, aa} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
        e.sum  = full[31:0] & mask;
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
        return e;
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic cin, input logic sub);
        case (sel)
            0: begin if_m.in_valid = v;  if_m.a = a[15:0];  if_m.b = b[15:0];  if_m.cin = cin;  if_m.sub = sub;  end
            1: begin if_1.in_valid = v;  if_1.a = a[15:0];  if_1.b = b[15:0];  if_1.cin = cin;  if_1.sub = sub;  end
            2: begin if_16.in_valid = v; if_16.a = a[15:0]; if_16.b = b[15:0]; if_16.cin = cin; if_16.sub = sub; end
            default: begin if_32.in_valid = v; if_32.a = a; if_32.b = b; if_32.cin = cin; if_32.sub = sub; end
        endcase
    endtask

    task automatic drive_ordy(input int sel, input logic r);
        case (sel)
            0:       if_m.out_ready  = r;
            1:       if_1.out_ready  = r;
            2:       if_16.out_ready = r;
            default: if_32.out_ready = r;
        endcase
    endtask

    task automatic sample(input int sel, output logic ir, output logic ov, output logic [31:0] s,
                          output logic co, output logic of);
        case (sel)
            0:       begin ir = if_m.in_ready;  ov = if_m.out_valid;  s = 32'(if_m.sum);  co = if_m.cout;  of = if_m.ovf;  end
            1:       begin ir = if_1.in_ready;  ov = if_1.out_valid;  s = 32'(if_1.sum);  co = if_1.cout;  of = if_1.ovf;  end
            2:       begin ir = if_16.in_ready; ov = if_16.out_valid; s = 32'(if_16.sum); co = if_16.cout; of = if_16.ovf; end
            default: begin ir = if_32.in_ready; ov = if_32.out_valid; s = if_32.sum;      co = if_32.cout; of = if_32.ovf; end
        endcase
    endtask

    // One transaction with out_ready high: latency, busy in_ready, result and return to IDLE.
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input string name);
        logic        ir, ov, co, of;
        logic [31:0] s;
        exp_t        e;
        int          edges;
        bit          busy_rdy;
        drive_ordy(sel, 1'b1);
        @(negedge clk);
        edges = 0;
        sample(sel, ir, ov, s, co, of);
        while (!ir && edges < 100) begin
            @(negedge clk);
            edges++;
            sample(sel, ir, ov, s, co, of);
        end
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", name, ir);
            return;
        end
        drive_in(sel, 1'b1, a, b, cin, sub);
        sb.push_back(model(w_of(sel), a, b, cin, sub));
        @(posedge clk);
        #1;
        drive_in(sel, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        edges    = 0;
        busy_rdy = 0;
        forever begin
            sample(sel, ir, ov, s, co, of);
            if (ov || edges >= 200) break;
            if (ir) busy_rdy = 1;
            @(posedge clk);
            #1;
            edges++;
        end
        e = sb.pop_front();
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b required 1", name, ov);
            return;
        end
        checks++;
        if (edges != nchunk_of(sel)) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", name, edges, nchunk_of(sel));
        end
        checks++;
        if (busy_rdy) begin
            errors++;
            $display("FAIL %s busy_in_ready: in_ready=1 required 0", name);
        end
        checks++;
        if (s !== e.sum || co !== e.cout || of !== e.ovf) begin
            errors++;
            $display("FAIL %s result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     name, s, co, of, e.sum, e.cout, e.ovf);
        end
        @(posedge clk);
        #1;
        sample(sel, ir, ov, s, co, of);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL %s consume: out_valid=%b in_ready=%b required 0 1", name, ov, ir);
        end
    endtask

    task automatic test_reset();
        logic        ir, ov, co, of;
        logic [31:0] s;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int sel = 0; sel < 4; sel++) begin
            sample(sel, ir, ov, s, co, of);
            checks++;
            if (ir !== 1'b1 || ov !== 1'b0 || s !== 32'h0 || co !== 1'b0 || of !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0",
                         sel, ir, ov, s, co, of);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        do_op(0, 32'h001F, 32'h000C, 1'b0, OP_ADD, "basic_add");
    endtask

    task automatic test_carry_ripple();
        do_op(0, 32'hFFFF, 32'h0000, 1'b1, OP_ADD, "carry_ripple");
    endtask

    task automatic test_subtract();
        do_op(0, 32'h0005, 32'h0007, 1'b1, OP_SUB, "sub_borrow");
        do_op(0, 32'h0007, 32'h0005, 1'b0, OP_SUB, "sub_noborrow");
    endtask

    task automatic test_overflow();
        do_op(0, 32'h7FFF, 32'h0001, 1'b0, OP_ADD, "ovf_pos");
        do_op(0, 32'hC61F, 32'h018C, 1'b1, OP_ADD, "ovf_none");
        do_op(0, 32'h8000, 32'h0001, 1'b0, OP_SUB, "ovf_sub");
    endtask

    task automatic test_backpressure();
        logic        ir, ov, co, of;
        logic [31:0] s;
        exp_t        e;
        int          edges;
        drive_ordy(0, 1'b0);
        @(negedge clk);
        drive_in(0, 1'b1, 32'h7FFF, 32'h0001, 1'b0, OP_ADD);
        sb.push_back(model(16, 32'h7FFF, 32'h0001, 1'b0, OP_ADD));
        @(posedge clk);
        #1;
        drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD);
        edges = 0;
        sample(0, ir, ov, s, co, of);
        while (!ov && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
            sample(0, ir, ov, s, co, of);
        end
        e = sb.pop_front();
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: out_valid=%b required 1", ov);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_in(0, 1'b1, $urandom, $urandom, 1'b0, OP_ADD);
            @(posedge clk);
            #1;
            sample(0, ir, ov, s, co, of);
            checks++;
            if (ov !== 1'b1 || ir !== 1'b0 || s !== e.sum || co !== e.cout || of !== e.ovf) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                         i, ov, ir, s, co, of, e.sum, e.cout, e.ovf);
            end
        end
        @(negedge clk);
        drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD);
        drive_ordy(0, 1'b1);
        @(posedge clk);
        #1;
        sample(0, ir, ov, s, co, of);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", ov, ir);
        end
    endtask

    task automatic test_reset_mid();
        logic        ir, ov, co, of;
        logic [31:0] s;
        bit          leaked;
        drive_ordy(0, 1'b1);
        @(negedge clk);
        drive_in(0, 1'b1, 32'h1111, 32'h2222, 1'b0, OP_ADD);
        @(posedge clk);
        #1;
        drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sample(0, ir, ov, s, co, of);
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0 || s !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b sum=%h required 1 0 0000", ir, ov, s);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        leaked = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            sample(0, ir, ov, s, co, of);
            if (ov) leaked = 1;
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL reset_mid_no_result: out_valid rose required 0");
        end
    endtask

    task automatic test_back_to_back();
        logic        ir, ov, co, of;
        logic [31:0] s;
        exp_t        e;
        int          cnt;
        bit          seen;
        drive_ordy(0, 1'b1);
        @(negedge clk);
        drive_in(0, 1'b1, 32'h1234, 32'h0F0F, 1'b1, OP_ADD);
        sb.push_back(model(16, 32'h1234, 32'h0F0F, 1'b1, OP_ADD));
        @(posedge clk);
        #1;
        // Operands for the second job appear while the first is still busy.
        drive_in(0, 1'b1, 32'hAAAA, 32'h5555, 1'b0, OP_SUB);
        sb.push_back(model(16, 32'hAAAA, 32'h5555, 1'b0, OP_SUB));
        cnt  = 0;
        seen = 0;
        ir   = 1'b0;
        while (!ir && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            sample(0, ir, ov, s, co, of);
            if (ov && !seen) begin
                seen = 1;
                e = sb.pop_front();
                checks++;
                if (s !== e.sum || co !== e.cout || of !== e.ovf) begin
                    errors++;
                    $display("FAIL b2b_first: sum=%h cout=%b ovf=%b required %h %b %b",
                             s, co, of, e.sum, e.cout, e.ovf);
                end
            end
        end
        checks++;
        if (!seen || cnt != 5) begin
            errors++;
            $display("FAIL b2b_gap: result_seen=%0d ready_after=%0d edges required 1 and 5", seen, cnt);
        end
        @(posedge clk);
        #1;
        drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD);
        sample(0, ir, ov, s, co, of);
        checks++;
        if (ir !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: in_ready=%b required 0", ir);
        end
        cnt = 0;
        while (!ov && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            sample(0, ir, ov, s, co, of);
        end
        if (sb.size() > 0) e = sb.pop_front();
        checks++;
        if (ov !== 1'b1 || s !== e.sum || co !== e.cout || of !== e.ovf) begin
            errors++;
            $display("FAIL b2b_second: out_valid=%b sum=%h cout=%b ovf=%b required 1 %h %b %b",
                     ov, s, co, of, e.sum, e.cout, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep(input int sel, input string name);
        for (int i = 0; i < 1000; i++) begin
            do_op(sel, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), name);
        end
    endtask

    initial begin
        for (int sel = 0; sel < 4; sel++) begin
            drive_in(sel, 1'b0, 32'h0, 32'h0, 1'b0, OP_ADD);
            drive_ordy(sel, 1'b1);
        end
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_subtract();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep(1, "sweep_c1");
        test_sweep(2, "sweep_c16");
        test_sweep(3, "sweep_w32");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
